spi_slave: RTL and testbench

- SPI slave endpoint for the opposite end of the link from the team's SPI_master; consumes sclk/mosi/cs, returns miso.
- Mode 0 (CPOL=0, CPHA=0), MSB first by default, DATA_W-bit frames, fully synchronous to the local system clock (sclk is oversampled, never used as a clock).
- Presents received words on a parallel rx port and accepts reply words through a valid/ready tx port.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_slave.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI slave endpoint.
//   DATA_W_DEF      : default frame width in bits
//   SYNC_STAGES_DEF : default synchronizer depth for sclk/mosi/cs
//   spi_state_e     : endpoint state encoding (IDLE / ACTIVE)
//   cnt_width()     : width of the in-frame bit counter
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Bit counter runs 0 .. w-1, so clog2(w) bits suffice; keep at least 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// STAGES-deep synchronizer for one asynchronous input, followed by a history
// flop that yields single-clk rise/fall pulses on the synchronized value.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   d_i          : asynchronous input
//   q_o          : synchronized level
//   rise_o       : one-clk pulse on synchronized 0->1
//   fall_o       : one-clk pulse on synchronized 1->0
// All flops reset to RESET_VAL so no spurious edge appears out of reset.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Mode-0 SPI slave, oversampled on clk (sclk is never used as a clock).
// Received frames appear on rx_data with a one-clk rx_valid pulse; reply
// words are taken through a one-entry tx buffer with a valid/ready handshake.
// Ports:
//   clk, reset_n       : system clock (>= 4x sclk), async active-low reset
//   sclk, mosi, cs     : SPI bus from the master (cs active low)
//   miso               : serial reply to the master, 0 while idle
//   rx_data, rx_valid  : last complete received word, update strobe
//   tx_data, tx_valid  : reply word offer
//   tx_ready           : tx buffer empty
//   busy               : synchronized cs asserted
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift rx and tx LSB first;
// default is MSB first.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | cs high; sclk ignored, miso held at 0
// ST_ACTIVE | cs low; sample mosi on sclk rise, advance miso on sclk fall
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy
);

    localparam int unsigned      CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d_i(cs),
        .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // mosi only needs the level; its edge outputs are deliberately dropped.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(mosi),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

    spi_state_e        state_q;
    logic [DATA_W-2:0] rx_shift_q;
    logic [DATA_W-2:0] tx_rem_q;      // tx bits still to go after the one on miso
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              miso_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] tx_buf_q;
    logic              tx_full_q;
    logic              busy_q;

    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-2:0] rx_keep;
    logic              first_bit;
    logic [DATA_W-2:0] rest_bits;
    logic              next_bit;
    logic [DATA_W-2:0] rem_shifted;
    logic              tx_accept;
    logic              tx_load;

    // An empty buffer at a frame start sends zeros (underrun).
    assign load_word = tx_full_q ? tx_buf_q : '0;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_word     = {mosi_s, rx_shift_q};
    assign rx_keep     = rx_word[DATA_W-1:1];
    assign first_bit   = load_word[0];
    assign rest_bits   = load_word[DATA_W-1:1];
    assign next_bit    = tx_rem_q[0];
    assign rem_shifted = tx_rem_q >> 1;
`else
    assign rx_word     = {rx_shift_q, mosi_s};
    assign rx_keep     = rx_word[DATA_W-2:0];
    assign first_bit   = load_word[DATA_W-1];
    assign rest_bits   = load_word[DATA_W-2:0];
    assign next_bit    = tx_rem_q[DATA_W-2];
    assign rem_shifted = tx_rem_q << 1;
`endif

    assign tx_accept = tx_valid && !tx_full_q;
    // Shifter reloads at cs entry and on the falling edge that closes a frame;
    // an abort in the same clk wins over the falling edge.
    assign tx_load   = ((state_q == ST_IDLE) && cs_fall) ||
                       ((state_q == ST_ACTIVE) && !cs_rise && sclk_fall &&
                        (bit_cnt_q == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rx_shift_q <= '0;
            tx_rem_q   <= '0;
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            // A same-clk accept only happens with the buffer empty, so the
            // load above already took zeros and the new word is kept.
            if (tx_accept) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end else if (tx_load) begin
                tx_full_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ST_ACTIVE;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        miso_q    <= first_bit;
                        tx_rem_q  <= rest_bits;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        bit_cnt_q  <= '0;
                        miso_q     <= 1'b0;
                        tx_rem_q   <= '0;
                        rx_shift_q <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_q <= rx_keep;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q  <= '0;
                                rx_data_q  <= rx_word;
                                rx_valid_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (bit_cnt_q == '0) begin
                                miso_q   <= first_bit;
                                tx_rem_q <= rest_bits;
                            end else begin
                                miso_q   <= next_bit;
                                tx_rem_q <= rem_shifted;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = !tx_full_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int LAT  = 3;   // synchronizer depth + 1
    localparam int HALF = 5;   // sclk half period in clk cycles (sclk = clk/10)

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .cs(cs),
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int rx_cyc = 0;
    int rx_long = 0;
    logic prev_v = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] last_seq;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (prev_v) rx_long++;
            else begin
                rx_q.push_back(rx_data);
                rx_cyc = cyc;
            end
        end
        prev_v = (rx_valid === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1);
    end

    // Word -> on-wire order (bit i = i-th bit on the wire); self-inverse.
    function automatic logic [7:0] to_seq(input logic [7:0] w);
        logic [7:0] r;
`ifdef SPI_SLAVE_LSB_FIRST_EN
        r = w;
`else
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
`endif
        return r;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_assert();
        wait_clks(1);
        cs = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_deassert();
        wait_clks(HALF);
        cs = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic xfer_seq(input logic [7:0] ms, input int nbits, output logic [7:0] ss);
        ss = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = ms[i];
            wait_clks(HALF);
            ss[i] = miso;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
        last_seq = ss;
    endtask

    task automatic xfer(input logic [7:0] mw, input int nbits, output logic [7:0] got);
        logic [7:0] ss;
        xfer_seq(to_seq(mw), nbits, ss);
        got = to_seq(ss);
    endtask

    task automatic push_tx(input logic [7:0] w);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            wait_clks(1);
            n++;
        end
        tests_run++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_tx_timeout tx_ready=%b required=1", tx_ready);
        end
        tx_data = w;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
    endtask

    // Reference: frame k returns tw[k] if supplied, else zeros; rx gets mw[k].
    task automatic run_burst(input int n, input logic [7:0] mw[4], input bit sup[4],
                             input logic [7:0] tw[4], output logic [7:0] got[4]);
        got = '{default: 8'h00};
        if (sup[0]) push_tx(tw[0]);
        cs_assert();
        for (int k = 0; k < n; k++) begin
            if (k + 1 < n && sup[k+1]) push_tx(tw[k+1]);
            xfer(mw[k], 8, got[k]);
            wait_clks(4);
        end
        cs_deassert();
    endtask

    task automatic test_reset();
        logic [7:0] got[4];
        logic [7:0] junk;
        wait_clks(3);
        tests_run++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", miso); end
        tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        tests_run++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        wait_clks(2);
        // Leave non-reset state behind, then reset in the middle of a frame.
        run_burst(1, '{8'h5A, 0, 0, 0}, '{1, 0, 0, 0}, '{8'h77, 0, 0, 0}, got);
        push_tx(8'h77);
        cs_assert();
        push_tx(8'h33);
        xfer(8'hFF, 3, junk);
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL premid_busy got=%b exp=1", busy); end
        tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL premid_tx_ready got=%b exp=0", tx_ready); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (miso !== 1'b0) begin fails++; $display("FAIL midreset_miso got=%b exp=0", miso); end
        tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midreset_rx_data got=%h exp=00", rx_data); end
        tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL midreset_tx_ready got=%b exp=1", tx_ready); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(4);
        rx_q.delete();
        run_burst(1, '{8'hA5, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, got);
        tests_run++; if (rx_q.size() !== 1) begin fails++; $display("FAIL postreset_rx_count got=%0d exp=1", rx_q.size()); end
        tests_run++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL postreset_rx_data got=%h exp=a5", rx_data); end
        tests_run++; if (got[0] !== 8'h00) begin fails++; $display("FAIL postreset_buffer_cleared got=%h exp=00", got[0]); end
    endtask

    task automatic test_single_frame();
        logic [7:0] got;
        logic [7:0] s;
        rx_q.delete();
        s = to_seq(8'h3C);
        push_tx(8'h3C);
        tests_run++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_tx_ready_full got=%b exp=0", tx_ready); end
        cs_assert();
        tests_run++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_tx_ready_after_cs got=%b exp=1", tx_ready); end
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got=%b exp=1", busy); end
        tests_run++; if (miso !== s[0]) begin fails++; $display("FAIL single_first_miso got=%b exp=%b", miso, s[0]); end
        xfer(8'h96, 8, got);
        cs_deassert();
        tests_run++; if (rx_q.size() !== 1) begin fails++; $display("FAIL single_rx_count got=%0d exp=1", rx_q.size()); end
        else begin
            tests_run++; if (rx_q[0] !== 8'h96) begin fails++; $display("FAIL single_rx_word got=%h exp=96", rx_q[0]); end
            tests_run++; if (rx_cyc - last_rise_cyc !== LAT) begin fails++; $display("FAIL single_rx_latency got=%0d exp=%0d", rx_cyc - last_rise_cyc, LAT); end
        end
        tests_run++; if (got !== 8'h3C) begin fails++; $display("FAIL single_miso_word got=%h exp=3c", got); end
        tests_run++; if (rx_long !== 0) begin fails++; $display("FAIL single_rx_valid_width got=%0d long exp=0", rx_long); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        tests_run++; if (miso !== 1'b0) begin fails++; $display("FAIL single_miso_idle got=%b exp=0", miso); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[4];
        rx_q.delete();
        run_burst(2, '{8'h01, 8'hFE, 0, 0}, '{1, 1, 0, 0}, '{8'h55, 8'hAA, 0, 0}, got);
        tests_run++; if (rx_q.size() !== 2) begin fails++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_q.size()); end
        else begin
            tests_run++; if (rx_q[0] !== 8'h01) begin fails++; $display("FAIL b2b_rx0 got=%h exp=01", rx_q[0]); end
            tests_run++; if (rx_q[1] !== 8'hFE) begin fails++; $display("FAIL b2b_rx1 got=%h exp=fe", rx_q[1]); end
        end
        tests_run++; if (got[0] !== 8'h55) begin fails++; $display("FAIL b2b_miso0 got=%h exp=55", got[0]); end
        tests_run++; if (got[1] !== 8'hAA) begin fails++; $display("FAIL b2b_miso1 got=%h exp=aa", got[1]); end
        tests_run++; if (rx_long !== 0) begin fails++; $display("FAIL b2b_rx_valid_width got=%0d exp=0", rx_long); end
    endtask

    task automatic test_underrun();
        logic [7:0] got[4];
        rx_q.delete();
        run_burst(1, '{8'hC3, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, got);
        tests_run++; if (got[0] !== 8'h00) begin fails++; $display("FAIL underrun_miso got=%h exp=00", got[0]); end
        tests_run++; if (rx_data !== 8'hC3) begin fails++; $display("FAIL underrun_rx got=%h exp=c3", rx_data); end
    endtask

    task automatic test_abort();
        logic [7:0] got[4];
        logic [7:0] junk;
        logic [7:0] prev;
        rx_q.delete();
        prev = rx_data;
        cs_assert();
        xfer(8'hFF, 5, junk);
        cs_deassert();
        tests_run++; if (rx_q.size() !== 0) begin fails++; $display("FAIL abort_rx_valid got=%0d pulses exp=0", rx_q.size()); end
        tests_run++; if (rx_data !== prev) begin fails++; $display("FAIL abort_rx_hold got=%h exp=%h", rx_data, prev); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests_run++; if (miso !== 1'b0) begin fails++; $display("FAIL abort_miso got=%b exp=0", miso); end
        run_burst(1, '{8'h12, 0, 0, 0}, '{1, 0, 0, 0}, '{8'h6B, 0, 0, 0}, got);
        tests_run++; if (rx_q.size() !== 1 || rx_data !== 8'h12) begin fails++; $display("FAIL abort_next_rx got=%h count=%0d exp=12 count=1", rx_data, rx_q.size()); end
        tests_run++; if (got[0] !== 8'h6B) begin fails++; $display("FAIL abort_next_miso got=%h exp=6b", got[0]); end
    endtask

    task automatic test_bit_order();
        logic [7:0] ss;
        logic [7:0] exp_rx, exp_seq;
`ifdef SPI_SLAVE_LSB_FIRST_EN
        exp_rx  = 8'h01;
        exp_seq = 8'b1000_0000;   // 0,0,0,0,0,0,0,1 on the wire
`else
        exp_rx  = 8'h80;
        exp_seq = 8'b0000_0001;   // 1,0,0,0,0,0,0,0 on the wire
`endif
        push_tx(8'h80);
        cs_assert();
        xfer_seq(8'b0000_0001, 8, ss);   // wire order 1,0,0,0,0,0,0,0
        cs_deassert();
        tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL order_rx got=%h exp=%h", rx_data, exp_rx); end
        tests_run++; if (ss !== exp_seq) begin fails++; $display("FAIL order_miso_seq got=%b exp=%b", ss, exp_seq); end
    endtask

    task automatic test_random();
        logic [7:0] mw[4];
        logic [7:0] tw[4];
        logic [7:0] got[4];
        bit sup[4];
        int n;
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                mw[k] = 8'($urandom);
                tw[k] = 8'($urandom);
                sup[k] = bit'($urandom_range(0, 1));
            end
            rx_q.delete();
            run_burst(n, mw, sup, tw, got);
            tests_run++;
            if (rx_q.size() !== n) begin
                fails++;
                $display("FAIL rand_rx_count it=%0d got=%0d exp=%0d", it, rx_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    tests_run++;
                    if (rx_q[k] !== mw[k]) begin fails++; $display("FAIL rand_rx it=%0d k=%0d got=%h exp=%h", it, k, rx_q[k], mw[k]); end
                end
            end
            for (int k = 0; k < n; k++) begin
                tests_run++;
                if (got[k] !== (sup[k] ? tw[k] : 8'h00)) begin
                    fails++;
                    $display("FAIL rand_miso it=%0d k=%0d got=%h exp=%h", it, k, got[k], sup[k] ? tw[k] : 8'h00);
                end
            end
            tests_run++;
            if (tx_ready !== 1'b1) begin fails++; $display("FAIL rand_tx_ready it=%0d got=%b exp=1", it, tx_ready); end
        end
        tests_run++; if (rx_long !== 0) begin fails++; $display("FAIL rand_rx_valid_width got=%0d exp=0", rx_long); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_bit_order();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
